// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encodings and frame geometry.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock holding FIFO between the producer and the UART shifter.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, oversampled bit timing, FIFO-buffered.
// Back-to-back frames start on the edge that ends the previous stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter  int OVERSAMPLE = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              tick,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state,
  output logic [CW-1:0]     count
);

  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

  uart_state_e       state_q;
  logic [3:0]        phase_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q;
  logic              done_q;

  logic              full, empty;
  logic              push, pop, wrap;
  logic [DATA_W-1:0] head;

  assign wrap = phase_q == LAST;
  assign push = valid && !full;
  assign pop  = !empty &&
                ((state_q == IDLE) ||
                 (state_q == STOP && wrap));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk_i   (tick),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (data),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge tick or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= head;
            phase_q <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          phase_q <= phase_q + 4'd1;
          if (wrap) begin
            phase_q <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          phase_q <= phase_q + 4'd1;
          if (wrap) begin
            phase_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
              done_q  <= OVERSAMPLE == 1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        STOP: begin
          phase_q <= phase_q + 4'd1;
          if (wrap) begin
            phase_q <= '0;
            if (pop) begin
              shift_q <= head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else if (phase_q == LAST - 4'd1) begin
            // high during the final stop-bit tick
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign ready = !full;
  assign tx    = tx_q;
  assign done  = done_q;
  assign busy  = state_q != IDLE;
  assign state = state_q;

endmodule
